// File: rtl/network_stack_rx_if.sv
// PHY-side receive pins and the payload/header result bus of the receive stack.
// The master modport is the side that drives the PHY pins (PHY model or bench).
// The slave modport is the receive stack itself.
interface network_stack_rx_if #(
    parameter int N         = 2,
    parameter int DATA_SIZE = 16
);
    logic                 eth_crsdv;
    logic [N-1:0]         eth_rxd;
    logic                 axiov;
    logic [DATA_SIZE-1:0] axiod;
    logic                 axio_last;
    logic                 frame_done;
    logic                 frame_good;
    logic [47:0]          src_mac_out;
    logic [31:0]          src_ip_out;
    logic [15:0]          udp_src_port_out;
    logic [15:0]          udp_dst_port_out;

    modport master (
        output eth_crsdv, eth_rxd,
        input  axiov, axiod, axio_last, frame_done, frame_good,
        input  src_mac_out, src_ip_out, udp_src_port_out, udp_dst_port_out
    );

    modport slave (
        input  eth_crsdv, eth_rxd,
        output axiov, axiod, axio_last, frame_done, frame_good,
        output src_mac_out, src_ip_out, udp_src_port_out, udp_dst_port_out
    );
endinterface

// File: rtl/network_stack_rx.sv
// RMII receive stack: preamble/SFD detection, Ethernet II / IPv4 / UDP header
// parsing and filtering, UDP payload packing into DATA_SIZE-bit words, and an
// FCS (CRC-32) check that qualifies every frame reaching the payload stage.
module network_stack_rx #(
    parameter int          N         = 2,
    parameter int          DATA_SIZE = 16,
    parameter logic [31:0] MY_IP     = 32'h12_12_6b_0d
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [47:0]       mac,
    network_stack_rx_if.slave rx
);

    localparam int         BYTES     = DATA_SIZE / 8;
    localparam logic [1:0] LAST_LANE = 2'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREAMBLE  = 3'd1,
        S_ETHERNET  = 3'd2,
        S_NETWORK   = 3'd3,
        S_TRANSPORT = 3'd4,
        S_DATA      = 3'd5,
        S_TAIL      = 3'd6,
        S_DROP      = 3'd7
    } state_t;

    // One byte step of the reflected IEEE 802.3 CRC-32 (poly EDB88320).
    function automatic logic [31:0] crc32_byte_f(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    // Byte idx (0 = first on the wire) of the local MAC address.
    function automatic logic [7:0] mac_byte_f(input logic [47:0] m, input logic [10:0] idx);
        case (idx)
            11'd0:   mac_byte_f = m[47:40];
            11'd1:   mac_byte_f = m[39:32];
            11'd2:   mac_byte_f = m[31:24];
            11'd3:   mac_byte_f = m[23:16];
            11'd4:   mac_byte_f = m[15:8];
            11'd5:   mac_byte_f = m[7:0];
            default: mac_byte_f = 8'h00;
        endcase
    endfunction

    // Expected IPv4 header byte at destination-address offsets 16..19.
    function automatic logic [7:0] ip_byte_f(input logic [10:0] idx);
        case (idx)
            11'd16:  ip_byte_f = MY_IP[31:24];
            11'd17:  ip_byte_f = MY_IP[23:16];
            11'd18:  ip_byte_f = MY_IP[15:8];
            11'd19:  ip_byte_f = MY_IP[7:0];
            default: ip_byte_f = 8'h00;
        endcase
    endfunction

    state_t               state_r;
    logic [2:0]           pre_cnt_r;
    logic [1:0]           dibit_cnt_r;
    logic [5:0]           shift_r;
    logic [10:0]          byte_cnt_r;
    logic                 flag_mac_r;
    logic                 flag_bc_r;
    logic [47:0]          src_mac_sh_r;
    logic [31:0]          src_ip_sh_r;
    logic [15:0]          src_port_sh_r;
    logic [15:0]          dst_port_sh_r;
    logic [15:0]          udp_len_r;
    logic [15:0]          payload_len_r;
    logic [15:0]          pay_cnt_r;
    logic [1:0]           lane_r;
    logic [DATA_SIZE-1:0] word_r;
    logic [31:0]          dl_r;
    logic [2:0]           fill_r;
    logic [31:0]          crc_r;

    logic                 axiov_r;
    logic [DATA_SIZE-1:0] axiod_r;
    logic                 axio_last_r;
    logic                 frame_done_r;
    logic                 frame_good_r;
    logic [47:0]          src_mac_out_r;
    logic [31:0]          src_ip_out_r;
    logic [15:0]          udp_src_port_out_r;
    logic [15:0]          udp_dst_port_out_r;

    logic                 crsdv_s;
    logic [N-1:0]         dibit_s;
    logic [7:0]           byte_s;
    logic                 mac_hit_s;
    logic                 bc_hit_s;
    logic                 last_byte_s;
    logic                 crc_ok_s;
    logic [DATA_SIZE-1:0] word_next_s;

    assign crsdv_s = rx.eth_crsdv;
    assign dibit_s = rx.eth_rxd;

    // Byte assembly, filter matches and end-of-payload / FCS status.
    always_comb begin
        byte_s      = {dibit_s, shift_r};
        mac_hit_s   = flag_mac_r && (byte_s == mac_byte_f(mac, byte_cnt_r));
        bc_hit_s    = flag_bc_r && (byte_s == 8'hFF);
        last_byte_s = (pay_cnt_r == (payload_len_r - 16'd1));
        crc_ok_s    = (dl_r == (crc_r ^ 32'hFFFFFFFF));
    end

    // Drop the incoming payload byte into its lane, first byte in the MSBs.
    always_comb begin
        word_next_s = word_r;
        for (int k = 0; k < BYTES; k++) begin
            word_next_s[DATA_SIZE-1-8*k -: 8] = (lane_r == 2'(k)) ? byte_s : word_r[DATA_SIZE-1-8*k -: 8];
        end
    end

    // Receive FSM together with header shadows, payload packing and FCS tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r            <= S_IDLE;
            pre_cnt_r          <= 3'd0;
            dibit_cnt_r        <= 2'd0;
            shift_r            <= 6'd0;
            byte_cnt_r         <= 11'd0;
            flag_mac_r         <= 1'b0;
            flag_bc_r          <= 1'b0;
            src_mac_sh_r       <= 48'd0;
            src_ip_sh_r        <= 32'd0;
            src_port_sh_r      <= 16'd0;
            dst_port_sh_r      <= 16'd0;
            udp_len_r          <= 16'd0;
            payload_len_r      <= 16'd0;
            pay_cnt_r          <= 16'd0;
            lane_r             <= 2'd0;
            word_r             <= {DATA_SIZE{1'b0}};
            dl_r               <= 32'd0;
            fill_r             <= 3'd0;
            crc_r              <= 32'hFFFFFFFF;
            axiov_r            <= 1'b0;
            axiod_r            <= {DATA_SIZE{1'b0}};
            axio_last_r        <= 1'b0;
            frame_done_r       <= 1'b0;
            frame_good_r       <= 1'b0;
            src_mac_out_r      <= 48'd0;
            src_ip_out_r       <= 32'd0;
            udp_src_port_out_r <= 16'd0;
            udp_dst_port_out_r <= 16'd0;
        end else begin
            axiov_r      <= 1'b0;
            axio_last_r  <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (crsdv_s && (dibit_s == 2'b01)) begin
                        state_r   <= S_PREAMBLE;
                        pre_cnt_r <= 3'd1;
                    end
                end
                S_PREAMBLE: begin
                    if (!crsdv_s) begin
                        state_r <= S_IDLE;
                    end else if (dibit_s == 2'b01) begin
                        if (pre_cnt_r != 3'd4) begin
                            pre_cnt_r <= pre_cnt_r + 3'd1;
                        end
                    end else if ((dibit_s == 2'b11) && (pre_cnt_r == 3'd4)) begin
                        state_r     <= S_ETHERNET;
                        byte_cnt_r  <= 11'd0;
                        dibit_cnt_r <= 2'd0;
                        fill_r      <= 3'd0;
                        crc_r       <= 32'hFFFFFFFF;
                        flag_mac_r  <= 1'b1;
                        flag_bc_r   <= 1'b1;
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!crsdv_s) begin
                        state_r <= S_IDLE;
                    end
                end
                S_ETHERNET, S_NETWORK, S_TRANSPORT, S_DATA, S_TAIL: begin
                    if (!crsdv_s) begin
                        // Frames that never reached the payload vanish silently.
                        state_r <= S_IDLE;
                        if ((state_r == S_DATA) || (state_r == S_TAIL)) begin
                            frame_done_r <= 1'b1;
                            frame_good_r <= (state_r == S_TAIL) && crc_ok_s && (dibit_cnt_r == 2'd0);
                        end
                    end else begin
                        shift_r     <= byte_s[7:2];
                        dibit_cnt_r <= dibit_cnt_r + 2'd1;
                        if (dibit_cnt_r == 2'd3) begin
                            // The delay line holds back the last four bytes so the
                            // FCS itself never enters the CRC.
                            dl_r       <= {byte_s, dl_r[31:8]};
                            byte_cnt_r <= byte_cnt_r + 11'd1;
                            if (fill_r == 3'd4) begin
                                crc_r <= crc32_byte_f(crc_r, dl_r[7:0]);
                            end else begin
                                fill_r <= fill_r + 3'd1;
                            end
                            case (state_r)
                                S_ETHERNET: begin
                                    case (byte_cnt_r)
                                        11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5: begin
                                            flag_mac_r <= mac_hit_s;
                                            flag_bc_r  <= bc_hit_s;
                                            if (!mac_hit_s && !bc_hit_s) begin
                                                state_r <= S_DROP;
                                            end
                                        end
                                        11'd6, 11'd7, 11'd8, 11'd9, 11'd10, 11'd11: begin
                                            src_mac_sh_r <= {src_mac_sh_r[39:0], byte_s};
                                        end
                                        11'd12: begin
                                            if (byte_s != 8'h08) begin
                                                state_r <= S_DROP;
                                            end
                                        end
                                        11'd13: begin
                                            if (byte_s != 8'h00) begin
                                                state_r <= S_DROP;
                                            end else begin
                                                state_r    <= S_NETWORK;
                                                byte_cnt_r <= 11'd0;
                                            end
                                        end
                                        default: begin
                                        end
                                    endcase
                                end
                                S_NETWORK: begin
                                    case (byte_cnt_r)
                                        11'd0: begin
                                            if (byte_s != 8'h45) begin
                                                state_r <= S_DROP;
                                            end
                                        end
                                        11'd9: begin
                                            if (byte_s != 8'h11) begin
                                                state_r <= S_DROP;
                                            end
                                        end
                                        11'd12, 11'd13, 11'd14, 11'd15: begin
                                            src_ip_sh_r <= {src_ip_sh_r[23:0], byte_s};
                                        end
                                        11'd16, 11'd17, 11'd18: begin
                                            if (byte_s != ip_byte_f(byte_cnt_r)) begin
                                                state_r <= S_DROP;
                                            end
                                        end
                                        11'd19: begin
                                            if (byte_s != ip_byte_f(byte_cnt_r)) begin
                                                state_r <= S_DROP;
                                            end else begin
                                                state_r    <= S_TRANSPORT;
                                                byte_cnt_r <= 11'd0;
                                            end
                                        end
                                        default: begin
                                        end
                                    endcase
                                end
                                S_TRANSPORT: begin
                                    case (byte_cnt_r)
                                        11'd0, 11'd1: src_port_sh_r <= {src_port_sh_r[7:0], byte_s};
                                        11'd2, 11'd3: dst_port_sh_r <= {dst_port_sh_r[7:0], byte_s};
                                        11'd4, 11'd5: udp_len_r     <= {udp_len_r[7:0], byte_s};
                                        11'd7: begin
                                            if (udp_len_r < 16'd8) begin
                                                state_r <= S_DROP;
                                            end else begin
                                                src_mac_out_r      <= src_mac_sh_r;
                                                src_ip_out_r       <= src_ip_sh_r;
                                                udp_src_port_out_r <= src_port_sh_r;
                                                udp_dst_port_out_r <= dst_port_sh_r;
                                                payload_len_r      <= udp_len_r - 16'd8;
                                                pay_cnt_r          <= 16'd0;
                                                lane_r             <= 2'd0;
                                                word_r             <= {DATA_SIZE{1'b0}};
                                                state_r            <= (udp_len_r == 16'd8) ? S_TAIL : S_DATA;
                                            end
                                        end
                                        default: begin
                                        end
                                    endcase
                                end
                                S_DATA: begin
                                    pay_cnt_r <= pay_cnt_r + 16'd1;
                                    if ((lane_r == LAST_LANE) || last_byte_s) begin
                                        axiov_r     <= 1'b1;
                                        axiod_r     <= word_next_s;
                                        axio_last_r <= last_byte_s;
                                        word_r      <= {DATA_SIZE{1'b0}};
                                        lane_r      <= 2'd0;
                                    end else begin
                                        word_r <= word_next_s;
                                        lane_r <= lane_r + 2'd1;
                                    end
                                    if (last_byte_s) begin
                                        state_r <= S_TAIL;
                                    end
                                end
                                default: begin
                                    // TAIL: padding and FCS only feed the CRC path.
                                end
                            endcase
                        end
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign rx.axiov            = axiov_r;
    assign rx.axiod            = axiod_r;
    assign rx.axio_last        = axio_last_r;
    assign rx.frame_done       = frame_done_r;
    assign rx.frame_good       = frame_good_r;
    assign rx.src_mac_out      = src_mac_out_r;
    assign rx.src_ip_out       = src_ip_out_r;
    assign rx.udp_src_port_out = udp_src_port_out_r;
    assign rx.udp_dst_port_out = udp_dst_port_out_r;

endmodule

// File: tb/tb_network_stack_rx.sv
// Directed bench for network_stack_rx: builds complete RMII frames with a
// bench-side CRC-32 generator and checks payload words, frame status and the
// latched header fields against hand-chosen expected values.
module tb_network_stack_rx;

    localparam int          DS     = 16;
    localparam logic [47:0] MY_MAC = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BC_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] MY_IP  = 32'h12_12_6b_0d;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] mac;

    network_stack_rx_if #(.N(2), .DATA_SIZE(DS)) rx_if ();

    network_stack_rx #(.N(2), .DATA_SIZE(DS), .MY_IP(MY_IP)) dut (
        .clk (clk),
        .rst (rst),
        .mac (mac),
        .rx  (rx_if)
    );

    always #10 clk = ~clk;

    int           total_cnt = 0;
    int           bad_cnt   = 0;
    logic [15:0]  word_q[$];
    logic         last_q[$];
    int           done_cnt  = 0;
    logic         good_seen = 1'b0;
    logic [7:0]   fr_q[$];
    logic [7:0]   pl_q[$];

    // Record delivered words and frame completions, away from the active edge.
    always @(negedge clk) begin
        if (rx_if.axiov) begin
            word_q.push_back(rx_if.axiod);
            last_q.push_back(rx_if.axio_last);
        end
        if (rx_if.frame_done) begin
            done_cnt++;
            good_seen = rx_if.frame_good;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] etype, input logic [31:0] dip,
                               input logic [47:0] smac, input logic [31:0] sip,
                               input logic [15:0] sp, input logic [15:0] dp, input logic [31:0] flip);
        logic [31:0] c;
        logic [15:0] ulen;
        logic [15:0] iplen;
        fr_q.delete();
        ulen  = 16'(8 + pl_q.size());
        iplen = ulen + 16'd20;
        for (int i = 5; i >= 0; i--) fr_q.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr_q.push_back(smac[8*i +: 8]);
        fr_q.push_back(etype[15:8]); fr_q.push_back(etype[7:0]);
        fr_q.push_back(8'h45); fr_q.push_back(8'h00);
        fr_q.push_back(iplen[15:8]); fr_q.push_back(iplen[7:0]);
        fr_q.push_back(8'h00); fr_q.push_back(8'h00); fr_q.push_back(8'h00); fr_q.push_back(8'h00);
        fr_q.push_back(8'h40); fr_q.push_back(8'h11); fr_q.push_back(8'h00); fr_q.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fr_q.push_back(sip[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr_q.push_back(dip[8*i +: 8]);
        fr_q.push_back(sp[15:8]); fr_q.push_back(sp[7:0]);
        fr_q.push_back(dp[15:8]); fr_q.push_back(dp[7:0]);
        fr_q.push_back(ulen[15:8]); fr_q.push_back(ulen[7:0]);
        fr_q.push_back(8'h00); fr_q.push_back(8'h00);
        foreach (pl_q[i]) fr_q.push_back(pl_q[i]);
        c = 32'hFFFFFFFF;
        foreach (fr_q[i]) c = crc_bits(c, fr_q[i]);
        c = ~c ^ flip;
        for (int i = 0; i < 4; i++) fr_q.push_back(c[8*i +: 8]);
    endtask

    task automatic send_dibit(input logic [1:0] d);
        @(negedge clk);
        rx_if.eth_crsdv = 1'b1;
        rx_if.eth_rxd   = d;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2]);
    endtask

    task automatic send_pre();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) send_byte(fr_q[i]);
    endtask

    task automatic end_frame(input int gap);
        @(negedge clk);
        rx_if.eth_crsdv = 1'b0;
        rx_if.eth_rxd   = 2'b00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_obs();
        word_q.delete();
        last_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_frame(input string tag, input int nw, input logic [15:0] w0, input logic l0,
                               input logic [15:0] w1, input logic l1, input int nd, input logic g);
        check_val({tag, "_nwords"}, word_q.size(), nw);
        if (nw >= 1 && word_q.size() >= 1) begin
            check_val({tag, "_w0"}, word_q[0], w0);
            check_val({tag, "_last0"}, last_q[0], l0);
        end
        if (nw >= 2 && word_q.size() >= 2) begin
            check_val({tag, "_w1"}, word_q[1], w1);
            check_val({tag, "_last1"}, last_q[1], l1);
        end
        check_val({tag, "_done"}, done_cnt, nd);
        if (nd > 0) check_val({tag, "_good"}, good_seen, g);
    endtask

    task automatic check_hdr(input string tag, input logic [47:0] smac, input logic [31:0] sip,
                             input logic [15:0] sp, input logic [15:0] dp);
        check_val({tag, "_smac"}, rx_if.src_mac_out, smac);
        check_val({tag, "_sip"}, rx_if.src_ip_out, sip);
        check_val({tag, "_sport"}, rx_if.udp_src_port_out, sp);
        check_val({tag, "_dport"}, rx_if.udp_dst_port_out, dp);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_axiov"}, rx_if.axiov, 1'b0);
        check_val({tag, "_axiod"}, rx_if.axiod, 16'h0000);
        check_val({tag, "_last"}, rx_if.axio_last, 1'b0);
        check_val({tag, "_fdone"}, rx_if.frame_done, 1'b0);
        check_val({tag, "_fgood"}, rx_if.frame_good, 1'b0);
        check_hdr(tag, 48'd0, 32'd0, 16'd0, 16'd0);
    endtask

    localparam logic [47:0] SMAC1 = 48'hA0_B1_C2_D3_E4_F5;
    localparam logic [31:0] SIP1  = 32'hC0_A8_01_07;

    initial begin
        rst             = 1'b1;
        mac             = MY_MAC;
        rx_if.eth_crsdv = 1'b0;
        rx_if.eth_rxd   = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("por");

        // Valid unicast frame, payload DE AD BE EF.
        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(MY_MAC, 16'h0800, MY_IP, SMAC1, SIP1, 16'h1234, 16'h5678, 32'd0);
        clear_obs(); send_pre(); send_bytes(fr_q.size()); end_frame(4);
        check_frame("good4", 2, 16'hDEAD, 1'b0, 16'hBEEF, 1'b1, 1, 1'b1);
        check_hdr("good4", SMAC1, SIP1, 16'h1234, 16'h5678);

        // Same frame with one FCS bit flipped.
        build_frame(MY_MAC, 16'h0800, MY_IP, SMAC1, SIP1, 16'h1234, 16'h5678, 32'd1);
        clear_obs(); send_pre(); send_bytes(fr_q.size()); end_frame(4);
        check_frame("badfcs", 2, 16'hDEAD, 1'b0, 16'hBEEF, 1'b1, 1, 1'b0);

        // Wrong destination IP: nothing delivered, header outputs untouched.
        build_frame(MY_MAC, 16'h0800, 32'h12_12_6b_0e, 48'h66_55_44_33_22_11, 32'h0A_00_00_01,
                    16'h1111, 16'h2222, 32'd0);
        clear_obs(); send_pre(); send_bytes(fr_q.size()); end_frame(4);
        check_frame("badip", 0, 16'h0, 1'b0, 16'h0, 1'b0, 0, 1'b0);
        check_hdr("badip", SMAC1, SIP1, 16'h1234, 16'h5678);

        // Broadcast ARP dropped, then a broadcast UDP frame one idle cycle later.
        build_frame(BC_MAC, 16'h0806, MY_IP, 48'h10_20_30_40_50_60, 32'h0A_0A_0A_0A,
                    16'h3333, 16'h4444, 32'd0);
        clear_obs(); send_pre(); send_bytes(fr_q.size()); end_frame(0);
        check_val("arp_nwords", word_q.size(), 0);
        pl_q = '{8'h01, 8'h02, 8'h03};
        build_frame(BC_MAC, 16'h0800, MY_IP, 48'h0A_0B_0C_0D_0E_0F, 32'hAC_10_00_09,
                    16'h4000, 16'h4001, 32'd0);
        send_pre(); send_bytes(fr_q.size()); end_frame(4);
        check_frame("pay3", 2, 16'h0102, 1'b0, 16'h0300, 1'b1, 1, 1'b1);
        check_hdr("pay3", 48'h0A_0B_0C_0D_0E_0F, 32'hAC_10_00_09, 16'h4000, 16'h4001);

        // Carrier drops after the first payload word of four payload bytes.
        pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(MY_MAC, 16'h0800, MY_IP, SMAC1, SIP1, 16'h1234, 16'h5678, 32'd0);
        clear_obs(); send_pre(); send_bytes(44); end_frame(4);
        check_frame("trunc", 1, 16'hDEAD, 1'b0, 16'h0, 1'b0, 1, 1'b0);

        // Valid frame so that outputs are non-zero before the reset test.
        build_frame(MY_MAC, 16'h0800, MY_IP, SMAC1, SIP1, 16'hAAAA, 16'hBBBB, 32'd0);
        clear_obs(); send_pre(); send_bytes(fr_q.size()); end_frame(4);
        check_frame("pre_rst", 2, 16'hDEAD, 1'b0, 16'hBEEF, 1'b1, 1, 1'b1);
        check_hdr("pre_rst", SMAC1, SIP1, 16'hAAAA, 16'hBBBB);

        // Reset pulse in the middle of the Ethernet/IP header.
        clear_obs(); send_pre(); send_bytes(20);
        @(negedge clk);
        rst             = 1'b1;
        rx_if.eth_crsdv = 1'b0;
        rx_if.eth_rxd   = 2'b00;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_val("midrst_done", done_cnt, 0);
        check_val("midrst_nwords", word_q.size(), 0);

        // Reception resumes normally after the reset.
        clear_obs(); send_pre(); send_bytes(fr_q.size()); end_frame(4);
        check_frame("post_rst", 2, 16'hDEAD, 1'b0, 16'hBEEF, 1'b1, 1, 1'b1);
        check_hdr("post_rst", SMAC1, SIP1, 16'hAAAA, 16'hBBBB);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
